// File: rtl/float_compare_pipe_if.sv
// Operand/result handshake bundle for float_compare_pipe.
// Master drives operands and out_ready; slave is the comparator.
interface float_compare_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_int;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_result;
  logic         out_nan;
  logic         out_snan;

  modport master (
    output in_valid, in_a, in_b, in_int,
    output out_ready,
    input  in_ready, out_valid,
    input  out_result, out_nan, out_snan
  );

  modport slave (
    input  in_valid, in_a, in_b, in_int,
    input  out_ready,
    output in_ready, out_valid,
    output out_result, out_nan, out_snan
  );
endinterface

// File: rtl/float_compare_pipe.sv
// Three-stage float/int comparator with valid/ready flow control.
// Result: 00 eq, 01 a>b, 11 a<b, 10 unordered.
module float_compare_pipe #(
  parameter int EXP_W        = 8,
  parameter int MANT_W       = 23,
  parameter int FLUSH_DENORM = 1
) (
  input logic clk,
  input logic rst,
  float_compare_pipe_if.slave io
);
  localparam int W = 1 + EXP_W + MANT_W;
  localparam logic FLUSH = (FLUSH_DENORM != 0);

  typedef struct packed {
    logic         v;
    logic         is_int;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         nan_a;
    logic         nan_b;
    logic         snan_a;
    logic         snan_b;
    logic         zero_a;
    logic         zero_b;
  } s1_t;

  typedef struct packed {
    logic v;
    logic is_int;
    logic nan;
    logic snan;
    logic both_zero;
    logic sa;
    logic sb;
    logic gt;
    logic eq;
  } s2_t;

  s1_t s1, s1_d;
  s2_t s2, s2_d;
  logic adv;
  logic [1:0] res_d;

  // {nan, snan, zero}; subnormals fold into zero when flushing
  function automatic logic [2:0] classify(
    input logic [W-1:0] x
  );
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic nan, snan, zero;
    e    = x[W-2:MANT_W];
    m    = x[MANT_W-1:0];
    nan  = (&e) & (|m);
    snan = nan & ~m[MANT_W-1];
    zero = (~|e) & (FLUSH | ~(|m));
    return {nan, snan, zero};
  endfunction

  assign adv         = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;

  // S1 input: operands plus per-operand classes
  always_comb begin
    logic [2:0] ca, cb;
    ca          = classify(io.in_a);
    cb          = classify(io.in_b);
    s1_d        = '0;
    s1_d.v      = io.in_valid;
    s1_d.is_int = io.in_int;
    s1_d.a      = io.in_a;
    s1_d.b      = io.in_b;
    s1_d.nan_a  = ca[2];
    s1_d.snan_a = ca[1];
    s1_d.zero_a = ca[0];
    s1_d.nan_b  = cb[2];
    s1_d.snan_b = cb[1];
    s1_d.zero_b = cb[0];
  end

  // S2 input: signs, magnitude order, merged flags
  always_comb begin
    logic [W-2:0] ma, mb;
    ma             = s1.a[W-2:0];
    mb             = s1.b[W-2:0];
    s2_d           = '0;
    s2_d.v         = s1.v;
    s2_d.is_int    = s1.is_int;
    s2_d.nan       = s1.nan_a | s1.nan_b;
    s2_d.snan      = s1.snan_a | s1.snan_b;
    s2_d.both_zero = s1.zero_a & s1.zero_b;
    s2_d.sa        = s1.a[W-1];
    s2_d.sb        = s1.b[W-1];
    if (s1.is_int) begin
      s2_d.gt = $signed(s1.a) > $signed(s1.b);
      s2_d.eq = s1.a == s1.b;
    end else begin
      s2_d.gt = ma > mb;
      s2_d.eq = ma == mb;
    end
  end

  // S3 input: final 2-bit code
  always_comb begin
    logic f_nan, f_zero, f_sign, f_mag;
    f_nan  = !s2.is_int & s2.nan;
    f_zero = !s2.is_int & !s2.nan
           & s2.both_zero;
    f_sign = !s2.is_int & !s2.nan
           & !s2.both_zero & (s2.sa != s2.sb);
    f_mag  = !s2.is_int & !s2.nan
           & !s2.both_zero & (s2.sa == s2.sb);
    res_d  = 2'b00;
    unique case (1'b1)
      f_nan:  res_d = 2'b10;
      f_zero: res_d = 2'b00;
      f_sign: res_d = s2.sa ? 2'b11 : 2'b01;
      f_mag: begin
        if (s2.eq)
          res_d = 2'b00;
        else
          res_d = (s2.gt ^ s2.sa) ? 2'b01 : 2'b11;
      end
      s2.is_int: begin
        if (s2.eq)
          res_d = 2'b00;
        else
          res_d = s2.gt ? 2'b01 : 2'b11;
      end
      default: res_d = 2'b00;
    endcase
  end

  // S1 register: shifts on every advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s1 <= '0;
    else if (adv)
      s1 <= s1_d;
  end

  // S2 register: shifts on every advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s2 <= '0;
    else if (adv)
      s2 <= s2_d;
  end

  // S3 output registers; data held across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.out_valid  <= 1'b0;
      io.out_result <= 2'b00;
      io.out_nan    <= 1'b0;
      io.out_snan   <= 1'b0;
    end else if (adv) begin
      io.out_valid <= s2.v;
      if (s2.v) begin
        io.out_result <= res_d;
        io.out_nan    <= !s2.is_int & s2.nan;
        io.out_snan   <= !s2.is_int & s2.snan;
      end
    end
  end
endmodule

// File: tb/tb_float_compare_pipe.sv
// Directed bench for float_compare_pipe: three parameter sets
// driven in lockstep, plus stream, backpressure and reset tests.
module tb_float_compare_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_compare_pipe_if #(.W(32)) if0 ();
  float_compare_pipe_if #(.W(32)) if1 ();
  float_compare_pipe_if #(.W(16)) if2 ();

  float_compare_pipe u0 (
    .clk(clk), .rst(rst), .io(if0.slave)
  );
  float_compare_pipe #(
    .FLUSH_DENORM(0)
  ) u1 (
    .clk(clk), .rst(rst), .io(if1.slave)
  );
  float_compare_pipe #(
    .EXP_W(5), .MANT_W(10)
  ) u2 (
    .clk(clk), .rst(rst), .io(if2.slave)
  );

  // reference: sortable-key ordering of float32 / signed int
  function automatic logic [1:0] model(
    input logic [31:0] a, b, input logic im
  );
    logic [31:0] ka, kb;
    logic za, zb;
    if (im) begin
      if (a == b) return 2'b00;
      return ($signed(a) > $signed(b)) ? 2'b01 : 2'b11;
    end
    if ((a[30:23] == 8'hFF && a[22:0] != 0)
     || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 2'b10;
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    if (za && zb) return 2'b00;
    ka = za ? 32'h8000_0000
       : (a[31] ? ~a : (a ^ 32'h8000_0000));
    kb = zb ? 32'h8000_0000
       : (b[31] ? ~b : (b ^ 32'h8000_0000));
    if (ka == kb) return 2'b00;
    return (ka > kb) ? 2'b01 : 2'b11;
  endfunction

  task automatic drive_all(
    input logic v, input logic [31:0] a, b,
    input logic im
  );
    if0.in_valid = v; if0.in_a = a;
    if0.in_b = b; if0.in_int = im;
    if1.in_valid = v; if1.in_a = a;
    if1.in_b = b; if1.in_int = im;
    if2.in_valid = v; if2.in_a = a[15:0];
    if2.in_b = b[15:0]; if2.in_int = im;
  endtask

  task automatic run_pair(
    input logic [31:0] a, b, input logic im,
    input int sel, output logic [1:0] r,
    output logic n, s, output int lat
  );
    drive_all(1'b1, a, b, im);
    @(posedge clk); #1;
    drive_all(1'b0, 32'h0, 32'h0, 1'b0);
    lat = 1;
    while (!if0.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    case (sel)
      1: begin
        r = if1.out_result;
        n = if1.out_nan; s = if1.out_snan;
      end
      2: begin
        r = if2.out_result;
        n = if2.out_nan; s = if2.out_snan;
      end
      default: begin
        r = if0.out_result;
        n = if0.out_nan; s = if0.out_snan;
      end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (if0.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b want 0",
               if0.out_valid);
    end
    tests++;
    if (if0.out_result !== 2'b00) begin
      fails++;
      $display("FAIL rst_result got %b want 00",
               if0.out_result);
    end
    tests++;
    if (if0.out_nan !== 1'b0
     || if0.out_snan !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags got %b%b want 00",
               if0.out_nan, if0.out_snan);
    end
    tests++;
    if (if0.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_ready got %b want 1",
               if0.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_float;
    logic [1:0] r; logic n, s; int lat;
    run_pair(32'h3F800000, 32'h40000000,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b11 || n !== 1'b0) begin
      fails++;
      $display("FAIL one_vs_two got %b/%b want 11/0",
               r, n);
    end
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL latency got %0d want 3", lat);
    end
    run_pair(32'h40000000, 32'h3F800000,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b01) begin
      fails++;
      $display("FAIL two_vs_one got %b want 01", r);
    end
  endtask

  task automatic test_zero_neg;
    logic [1:0] r; logic n, s; int lat;
    run_pair(32'h80000000, 32'h00000000,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b00) begin
      fails++;
      $display("FAIL signed_zeros got %b want 00", r);
    end
    run_pair(32'hC0000000, 32'hBF800000,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b11) begin
      fails++;
      $display("FAIL neg2_vs_neg1 got %b want 11", r);
    end
    run_pair(32'hFF800000, 32'hFF7FFFFF,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b11) begin
      fails++;
      $display("FAIL neginf got %b want 11", r);
    end
  endtask

  task automatic test_nan;
    logic [1:0] r; logic n, s; int lat;
    run_pair(32'h7FC00000, 32'h3F800000,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b10 || n !== 1'b1 || s !== 1'b0) begin
      fails++;
      $display("FAIL qnan got %b/%b/%b want 10/1/0",
               r, n, s);
    end
    run_pair(32'h7F800001, 32'h3F800000,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b10 || n !== 1'b1 || s !== 1'b1) begin
      fails++;
      $display("FAIL snan got %b/%b/%b want 10/1/1",
               r, n, s);
    end
    run_pair(32'h7FC00000, 32'h00000001,
             1'b1, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b01 || n !== 1'b0 || s !== 1'b0) begin
      fails++;
      $display("FAIL int_mode got %b/%b/%b want 01/0/0",
               r, n, s);
    end
    run_pair(32'hFFFFFFFF, 32'h00000001,
             1'b1, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b11) begin
      fails++;
      $display("FAIL int_neg got %b want 11", r);
    end
  endtask

  task automatic test_denorm_param;
    logic [1:0] r; logic n, s; int lat;
    run_pair(32'h00000001, 32'h80000000,
             1'b0, 0, r, n, s, lat);
    tests++;
    if (r !== 2'b00) begin
      fails++;
      $display("FAIL denorm_flush got %b want 00", r);
    end
    run_pair(32'h00000001, 32'h80000000,
             1'b0, 1, r, n, s, lat);
    tests++;
    if (r !== 2'b01) begin
      fails++;
      $display("FAIL denorm_raw got %b want 01", r);
    end
    run_pair(32'h00003C00, 32'h0000BC00,
             1'b0, 2, r, n, s, lat);
    tests++;
    if (r !== 2'b01) begin
      fails++;
      $display("FAIL half_pos_neg got %b want 01", r);
    end
    run_pair(32'h00007C01, 32'h00003C00,
             1'b0, 2, r, n, s, lat);
    tests++;
    if (r !== 2'b10 || n !== 1'b1 || s !== 1'b1) begin
      fails++;
      $display("FAIL half_snan got %b/%b/%b want 10/1/1",
               r, n, s);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pa [8];
    logic [31:0] pb [8];
    logic        pi [8];
    logic [1:0]  q [$];
    logic [1:0]  e;
    int idx, got;
    logic saw_block, block_ok;
    for (int i = 0; i < 8; i++) begin
      pa[i] = $urandom;
      pb[i] = (i % 3 == 0) ? pa[i] : $urandom;
      pi[i] = (i == 5);
    end
    pb[2] = pa[2] ^ 32'h8000_0000;
    idx = 0; got = 0;
    saw_block = 1'b0; block_ok = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (idx < 8) begin
        if0.in_valid = 1'b1;
        if0.in_a = pa[idx]; if0.in_b = pb[idx];
        if0.in_int = pi[idx];
      end else begin
        if0.in_valid = 1'b0;
      end
      if0.out_ready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      if (if0.out_valid && !if0.out_ready) begin
        saw_block = 1'b1;
        if (if0.in_ready !== 1'b0) block_ok = 1'b0;
      end
      if (if0.out_valid && if0.out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra got %b want none",
                   if0.out_result);
        end else begin
          e = q.pop_front();
          if (if0.out_result !== e) begin
            fails++;
            $display("FAIL stream_%0d got %b want %b",
                     got, if0.out_result, e);
          end
        end
        got++;
      end
      if (if0.in_valid && if0.in_ready) begin
        q.push_back(model(pa[idx], pb[idx], pi[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    tests++;
    if (got !== 8 || q.size() !== 0) begin
      fails++;
      $display("FAIL stream_count got %0d want 8", got);
    end
    tests++;
    if (!saw_block || !block_ok) begin
      fails++;
      $display("FAIL backpressure got %b%b want 11",
               saw_block, block_ok);
    end
  endtask

  task automatic test_reset_midstream;
    int stale;
    if0.out_ready = 1'b1;
    drive_all(1'b1, 32'h40000000, 32'h3F800000, 1'b0);
    @(posedge clk); #1;
    drive_all(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
    @(posedge clk); #1;
    drive_all(1'b1, 32'h7FC00000, 32'h00000000, 1'b0);
    @(posedge clk); #1;
    drive_all(1'b0, 32'h0, 32'h0, 1'b0);
    tests++;
    if (if0.out_valid !== 1'b1
     || if0.out_result !== 2'b01) begin
      fails++;
      $display("FAIL pre_rst got %b/%b want 1/01",
               if0.out_valid, if0.out_result);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (if0.out_valid !== 1'b0
     || if0.out_result !== 2'b00) begin
      fails++;
      $display("FAIL mid_rst got %b/%b want 0/00",
               if0.out_valid, if0.out_result);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if0.out_valid) stale++;
    end
    tests++;
    if (stale !== 0) begin
      fails++;
      $display("FAIL stale_after_rst got %0d want 0",
               stale);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    drive_all(1'b0, 32'h0, 32'h0, 1'b0);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    test_reset();
    test_float();
    test_zero_neg();
    test_nan();
    test_denorm_param();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
